// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl
//   Moore-style main controller for a shared-resource multicycle MIPS
//   datapath. It decodes the IR opcode and drives the mux selects, the write
//   strobes and the 2-bit ALUOp. It also waits on a memory-ready handshake,
//   with a bounded wait timeout.
//
//   Handshake: a memory access in FETCH, MEMRD or MEMWR completes in the
//   cycle where mem_ready = 1. While mem_ready = 0 the state holds and the
//   wait counter advances. When the counter equals WAIT_MAX with
//   mem_ready still 0, the access is abandoned. In that cycle mem_err
//   pulses and no strobe asserts, and the next state is FETCH.
//   mem_ready = 1 in the limit cycle still completes the access normally.
//
//   Optional feature: define MC_JUMP_EN to decode op 000010 (j) into the
//   JUMP state. Without it, that opcode is reported as illegal.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   op[5:0]           opcode, IR[31:26]
//   zero              ALU zero flag (beq)
//   mem_ready         memory completes the current access this cycle
//   iord              memory address select (0 PC, 1 ALUOut)
//   mem_write         memory write enable
//   ir_write          IR load enable
//   reg_dst           write-register select (0 rt, 1 rd)
//   mem_to_reg        write-back select (0 ALUOut, 1 Data)
//   reg_write         register file write enable
//   alu_src_a         ALU A select (0 PC, 1 A)
//   alu_src_b[1:0]    ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   alu_op[1:0]       00 add, 01 sub, 10 use funct
//   pc_src[1:0]       00 ALUResult, 01 ALUOut, 10 jump target
//   pc_en             pc_write | (branch & zero)
//   illegal_op        one-cycle pulse on an undecodable opcode
//   mem_err           one-cycle pulse on wait timeout
//   state[3:0]        current state code (debug / checkers)
module multicycle_main_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_MAX);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting, timeout;
    logic             pc_write, branch;
    logic             mem_w, ir_w, reg_w, ill, err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only runs while a memory state is stalled. Every other
    // path clears it, so each entry to a memory state starts from zero.
    // This includes the timeout path back into FETCH.
    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                   (state_q == S_MEMWR)) && !mem_ready;
        timeout = (WAIT_MAX != 0) && waiting && (cnt_q == LIMIT);
        cnt_d   = '0;
        if (waiting && !timeout) begin
            // Saturate so a disabled timeout (WAIT_MAX = 0) never wraps.
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        ill        = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                if (timeout) begin
                    err     = 1'b1;
                    state_d = S_FETCH;
                end else if (mem_ready) begin
                    ir_w     = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = S_EXEC;
                    6'b000100:            state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
                    6'b000010:            state_d = S_JUMP;
`endif
                    default: begin
                        ill     = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == 6'b101011) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (timeout) begin
                    err     = 1'b1;
                    state_d = S_FETCH;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_w      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord = 1'b1;
                if (timeout) begin
                    err     = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mem_w = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst = 1'b1;
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
`endif
            // Unreachable codes recover to FETCH with every output at 0.
            default: state_d = S_FETCH;
        endcase
    end

    // While reset is high, the strobes are masked combinationally. This
    // stops a write that is in flight in the same cycle as reset.
    assign mem_write  = mem_w & ~reset;
    assign ir_write   = ir_w & ~reset;
    assign reg_write  = reg_w & ~reset;
    assign illegal_op = ill & ~reset;
    assign mem_err    = err & ~reset;
    assign pc_en      = (pc_write | (branch & zero)) & ~reset;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
module tb_multicycle_main_ctrl;

    // Expected-vector layout:
    // [19:16] state, 15 iord, 14 mem_write, 13 ir_write, 12 reg_dst,
    // 11 mem_to_reg, 10 reg_write, 9 alu_src_a, [8:7] alu_src_b,
    // [6:5] alu_op, [4:3] pc_src, 2 pc_en, 1 illegal_op, 0 mem_err
    localparam int W = 20;

    // Outputs of each state with no conditional strobes, written out by hand.
    localparam logic [W-1:0] B_FETCH  = {4'd0,  6'b000000, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_DECODE = {4'd1,  6'b000000, 1'b0, 2'b11, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_MEMADR = {4'd2,  6'b000000, 1'b1, 2'b10, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_MEMRD  = {4'd3,  6'b100000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_MEMWB  = {4'd4,  6'b000011, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_MEMWR  = {4'd5,  6'b110000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_EXEC   = {4'd6,  6'b000000, 1'b1, 2'b00, 2'b10, 2'b00, 3'b000};
    localparam logic [W-1:0] B_ALUWB  = {4'd7,  6'b000101, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_BRANCH = {4'd8,  6'b000000, 1'b1, 2'b00, 2'b01, 2'b01, 3'b000};
    localparam logic [W-1:0] B_ADDIEX = {4'd9,  6'b000000, 1'b1, 2'b10, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] B_ADDIWB = {4'd10, 6'b000001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000};
    localparam logic [W-1:0] M_MW   = 20'h04000;
    localparam logic [W-1:0] M_IRW  = 20'h02000;
    localparam logic [W-1:0] M_PCEN = 20'h00004;
    localparam logic [W-1:0] M_ILL  = 20'h00002;
    localparam logic [W-1:0] M_ERR  = 20'h00001;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [5:0] op = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal_op, mem_err;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    multicycle_main_ctrl #(.WAIT_MAX(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .pc_en(pc_en), .illegal_op(illegal_op),
        .mem_err(mem_err), .state(state)
    );

    logic [W-1:0] got;
    assign got = {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, mem_err};

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int checks = 0;
    int errors = 0;

    // monitor: outputs are valid every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            string        n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got=%05h exp=%05h (t=%0t)", n, got, e, $time);
            end
        end
    end

    // driver: apply this cycle's inputs, queue the expected outputs, advance
    task automatic step(input logic rst, input logic [5:0] o, input logic z,
                        input logic rdy, input logic [W-1:0] e, input string n);
        reset     = rst;
        op        = o;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_ok(input logic [5:0] o);
        step(1'b0, o, 1'b0, 1'b1, B_FETCH | M_IRW | M_PCEN, "fetch");
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got=no_finish exp=finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        @(posedge clk);
        #1;
        // reset: FETCH selects, strobes masked even with mem_ready high
        step(1'b1, OP_R, 1'b0, 1'b1, B_FETCH, "reset_fetch");
        step(1'b1, OP_R, 1'b0, 1'b0, B_FETCH, "reset_hold");

        // R-type: 0,1,6,7
        fetch_ok(OP_R);
        step(1'b0, OP_R, 1'b0, 1'b1, B_DECODE, "r_decode");
        step(1'b0, OP_R, 1'b0, 1'b1, B_EXEC,   "r_exec");
        step(1'b0, OP_R, 1'b0, 1'b1, B_ALUWB,  "r_aluwb");

        // lw with MEMRD held 4 cycles
        fetch_ok(OP_LW);
        step(1'b0, OP_LW, 1'b0, 1'b1, B_DECODE, "lw_decode");
        step(1'b0, OP_LW, 1'b0, 1'b1, B_MEMADR, "lw_memadr");
        for (int i = 0; i < 3; i++) step(1'b0, OP_LW, 1'b0, 1'b0, B_MEMRD, "lw_memrd_wait");
        step(1'b0, OP_LW, 1'b0, 1'b1, B_MEMRD, "lw_memrd_done");
        step(1'b0, OP_LW, 1'b0, 1'b1, B_MEMWB, "lw_memwb");

        // beq taken / not taken
        fetch_ok(OP_BEQ);
        step(1'b0, OP_BEQ, 1'b1, 1'b1, B_DECODE, "beq1_decode");
        step(1'b0, OP_BEQ, 1'b1, 1'b1, B_BRANCH | M_PCEN, "beq_taken");
        fetch_ok(OP_BEQ);
        step(1'b0, OP_BEQ, 1'b0, 1'b1, B_DECODE, "beq0_decode");
        step(1'b0, OP_BEQ, 1'b0, 1'b1, B_BRANCH, "beq_not_taken");

        // addi
        fetch_ok(OP_ADDI);
        step(1'b0, OP_ADDI, 1'b0, 1'b1, B_DECODE, "addi_decode");
        step(1'b0, OP_ADDI, 1'b0, 1'b1, B_ADDIEX, "addi_ex");
        step(1'b0, OP_ADDI, 1'b0, 1'b1, B_ADDIWB, "addi_wb");

        // sw with one wait cycle
        fetch_ok(OP_SW);
        step(1'b0, OP_SW, 1'b0, 1'b1, B_DECODE, "sw_decode");
        step(1'b0, OP_SW, 1'b0, 1'b1, B_MEMADR, "sw_memadr");
        step(1'b0, OP_SW, 1'b0, 1'b0, B_MEMWR,  "sw_memwr_wait");
        step(1'b0, OP_SW, 1'b0, 1'b1, B_MEMWR,  "sw_memwr_done");

        // illegal opcode
        fetch_ok(OP_BAD);
        step(1'b0, OP_BAD, 1'b0, 1'b1, B_DECODE | M_ILL, "illegal_decode");

        // jump opcode
        fetch_ok(OP_J);
`ifdef MC_JUMP_EN
        step(1'b0, OP_J, 1'b0, 1'b1, B_DECODE, "j_decode");
        step(1'b0, OP_J, 1'b0, 1'b1, {4'd11, 6'b000000, 1'b0, 2'b00, 2'b00, 2'b10, 3'b100}, "j_jump");
`else
        step(1'b0, OP_J, 1'b0, 1'b1, B_DECODE | M_ILL, "j_illegal");
`endif

        // FETCH timeout at WAIT_MAX = 4: counts 0..3 then error on count 4
        for (int i = 0; i < 4; i++) step(1'b0, OP_SW, 1'b0, 1'b0, B_FETCH, "fetch_wait");
        step(1'b0, OP_SW, 1'b0, 1'b0, B_FETCH | M_ERR, "fetch_timeout");
        // counter restarted: four more stalls stay quiet
        for (int i = 0; i < 4; i++) step(1'b0, OP_SW, 1'b0, 1'b0, B_FETCH, "fetch_rewait");

        // MEMWR timeout: no mem_write in the abort cycle
        fetch_ok(OP_SW);
        step(1'b0, OP_SW, 1'b0, 1'b1, B_DECODE, "swto_decode");
        step(1'b0, OP_SW, 1'b0, 1'b1, B_MEMADR, "swto_memadr");
        for (int i = 0; i < 4; i++) step(1'b0, OP_SW, 1'b0, 1'b0, B_MEMWR, "swto_wait");
        step(1'b0, OP_SW, 1'b0, 1'b0, (B_MEMWR & ~M_MW) | M_ERR, "memwr_timeout");

        // MEMRD: ready arrives exactly at the limit and wins
        fetch_ok(OP_LW);
        step(1'b0, OP_LW, 1'b0, 1'b1, B_DECODE, "lwlim_decode");
        step(1'b0, OP_LW, 1'b0, 1'b1, B_MEMADR, "lwlim_memadr");
        for (int i = 0; i < 4; i++) step(1'b0, OP_LW, 1'b0, 1'b0, B_MEMRD, "lwlim_wait");
        step(1'b0, OP_LW, 1'b0, 1'b1, B_MEMRD, "memrd_ready_at_limit");
        step(1'b0, OP_LW, 1'b0, 1'b1, B_MEMWB, "lwlim_memwb");

        // reset asserted mid-MEMWR: state and mem_write drop before any edge
        fetch_ok(OP_SW);
        step(1'b0, OP_SW, 1'b0, 1'b1, B_DECODE, "swrst_decode");
        step(1'b0, OP_SW, 1'b0, 1'b1, B_MEMADR, "swrst_memadr");
        step(1'b0, OP_SW, 1'b0, 1'b0, B_MEMWR,  "swrst_memwr");
        step(1'b1, OP_SW, 1'b0, 1'b0, B_FETCH,  "reset_in_memwr");
        step(1'b1, OP_SW, 1'b0, 1'b1, B_FETCH,  "reset_in_memwr_hold");
        fetch_ok(OP_R);
        step(1'b0, OP_R, 1'b0, 1'b1, B_DECODE, "post_reset_decode");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
- Moore-style main controller FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, register file, IR and PC.
- Decodes the IR opcode and drives the mux selects, write strobes and the 2-bit ALUOp consumed by the ALU decoder.
- Adds a memory-ready handshake and a bounded wait timeout, so the block can sit in front of a slow unified memory.

Parameters:
- WAIT_MAX, 15, maximum cycles spent waiting on mem_ready in any memory state before abort; 0 disables the timeout.
- CNT_W, 4, width of the wait counter; must hold WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  6  opcode, IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR load enable
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = Data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct
- pc_src  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable, equal to pc_write | (branch & zero)
- illegal_op  out  1  one-cycle pulse on an undecodable opcode
- mem_err  out  1  one-cycle pulse on wait timeout
- state  out  4  current state code, for debug and verification

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable; if entered, go to FETCH next cycle with all strobes 0.
- Reset: state = FETCH, wait counter = 0. While reset is high, all strobes are forced to 0 (mem_write, ir_write, reg_write, pc_en, illegal_op, mem_err); selects show their FETCH values.
- Any output not listed for a state is 0.
- FETCH: iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_src = 00.
  - ir_write and pc_write assert only in the cycle mem_ready = 1; then go to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 00. Next state by op:
  - 100011 (lw) and 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - anything else -> FETCH, with illegal_op = 1 for that cycle
- MEMADR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state: MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1. Go to MEMWB when mem_ready = 1, else hold.
- MEMWB: reg_dst = 0, mem_to_reg = 1, reg_write = 1. Next state FETCH.
- MEMWR: iord = 1, mem_write = 1 every cycle held. Go to FETCH when mem_ready = 1, else hold.
- EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10. Next state ALUWB.
- ALUWB: reg_dst = 1, mem_to_reg = 0, reg_write = 1. Next state FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, branch = 1. Next state FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next state ADDIWB.
- ADDIWB: reg_dst = 0, mem_to_reg = 0, reg_write = 1. Next state FETCH.
- Instruction latency with mem_ready tied high:
  - beq: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Wait counter (applies in FETCH, MEMRD and MEMWR only):
  - Clears on entry to each of these states; increments each cycle mem_ready = 0.
  - If WAIT_MAX != 0 and the counter equals WAIT_MAX with mem_ready = 0: mem_err = 1 for one cycle, no strobes that cycle, next state FETCH.
  - mem_ready = 1 in the same cycle as the limit wins; the access completes normally.
- pc_en is combinational from state and zero; pc_write and branch are internal decodes.
- Asynchronous reset mid-instruction returns to FETCH immediately. A pending mem_write drops in the same cycle.

Optional Feature:
- Macro MC_JUMP_EN.
- When defined: op 000010 in DECODE goes to JUMP. JUMP drives pc_src = 10 and pc_write = 1 (pc_en = 1), then goes to FETCH. j takes 3 cycles.
- When undefined: op 000010 is illegal; DECODE pulses illegal_op and returns to FETCH. State code 11 is unreachable.

Test Plan:
- R-type, op = 000000, mem_ready = 1 -> states 0,1,6,7,0. alu_op = 10 in EXEC; reg_write = 1 and reg_dst = 1 only in ALUWB.
- lw, op = 100011, mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with iord = 1. MEMWB asserts reg_write = 1 and mem_to_reg = 1. No mem_err.
- beq with zero = 1, then zero = 0 -> BRANCH shows pc_en = 1 and pc_en = 0 respectively. alu_op = 01, pc_src = 01 in both runs.
- WAIT_MAX = 4, mem_ready held 0 in FETCH -> mem_err pulse once the counter reaches 4. ir_write is never asserted; FETCH re-entered with counter cleared.
- op = 111111 -> illegal_op pulse in DECODE, next state FETCH, no reg_write or mem_write. op = 000010 -> JUMP with pc_src = 10 if MC_JUMP_EN is defined, illegal_op otherwise.
- reset asserted during MEMWR with mem_write = 1 -> mem_write = 0 and state = 0 in the same cycle. After release, FETCH resumes normally.
